// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory back end and the cache that drives it.
// Holds the read/write encoding, the request FSM state encoding and the
// latency counter width.
package mem_pkg;

    // Request direction, shared with the cache's RAM-side port
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Latency counter width; covers latencies 1..15
    localparam int unsigned CNT_W = 4;

    // Request FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Synchronous single-port word storage with a registered read port.
// Ports:
//   clk      - clock
//   rst_n    - async active-low reset, clears the read-data register only
//   we_i     - write enable; stores wdata_i at addr_i on the rising edge
//   addr_i   - word address
//   wdata_i  - write data
//   re_i     - read enable; loads rdata_o from addr_i on the rising edge
//   rdata_o  - registered read data, holds the last read
module mem_array #(
    parameter int unsigned d_width = 8,
    parameter int unsigned a_width = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [a_width-1:0] addr_i,
    input  logic [d_width-1:0] wdata_i,
    input  logic               re_i,
    output logic [d_width-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** a_width;

    logic [d_width-1:0] mem [DEPTH];
    logic [d_width-1:0] rdata_q;

    // Storage is deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Read-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array

// File: rtl/main_mem.sv
// Main-memory back end with configurable access latency.
// Accepts one read/write request at a time, completes it exactly `latency`
// clock edges after acceptance and signals completion with a one-cycle odv.
// Ports:
//   clk       - clock
//   clr       - async active-low reset
//   addr_in   - request address
//   data_in   - write data
//   rw_in     - 1 = read, 0 = write
//   ce_in     - request strobe, accepted only while idle
//   data_out  - read data, holds the last completed read
//   busy      - request in flight
//   odv       - one-cycle completion pulse (reads and writes)
//   ovr       - sticky: a request was attempted while busy
module main_mem
    import mem_pkg::*;
#(
    parameter int unsigned d_width = 8,
    parameter int unsigned a_width = 8,
    parameter int unsigned latency = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [a_width-1:0] addr_in,
    input  logic [d_width-1:0] data_in,
    input  logic               rw_in,
    input  logic               ce_in,
    output logic [d_width-1:0] data_out,
    output logic               busy,
    output logic               odv,
    output logic               ovr
);

    // Counter load value at acceptance; WAIT ends once it has counted to zero
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [a_width-1:0] addr_q, addr_d;
    logic [d_width-1:0] data_q, data_d;
    logic               rw_q, rw_d;
    logic               busy_q, busy_d;
    logic               odv_q, odv_d;
    logic               ovr_q, ovr_d;
    logic               we_c;
    logic               re_c;

    // State, request latches and flags
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= RW_READ;
            busy_q  <= 1'b0;
            odv_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            odv_q   <= odv_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state, counter, latch and array-strobe logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        odv_d   = 1'b0;
        ovr_d   = ovr_q;
        we_c    = 1'b0;
        re_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (ce_in) begin
                    addr_d  = addr_in;
                    data_d  = data_in;
                    rw_d    = rw_in;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                // The array access is issued on the edge that enters DONE, so
                // a reset anywhere before that edge drops the request cleanly.
                // A latency of one spends its single delay cycle here with the
                // counter already at zero.
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    odv_d   = 1'b1;
                    we_c    = (rw_q == RW_WRITE);
                    re_c    = (rw_q == RW_READ);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Strobes outside IDLE are dropped and remembered until reset
        if (ce_in && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    mem_array #(
        .d_width (d_width),
        .a_width (a_width)
    ) u_array (
        .clk     (clk),
        .rst_n   (clr),
        .we_i    (we_c),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .re_i    (re_c),
        .rdata_o (data_out)
    );

    assign busy = busy_q;
    assign odv  = odv_q;
    assign ovr  = ovr_q;

endmodule : main_mem

// File: tb/tb_main_mem.sv
// Self-checking bench for main_mem: four instances with latency 1..4 share
// the request bus; each has its own strobe and reset.
module tb_main_mem;
    import mem_pkg::*;

    localparam int unsigned NDUT = 4;

    logic            clk = 1'b0;
    logic [NDUT-1:0] clr;
    logic [NDUT-1:0] ce;
    logic [7:0]      addr_in;
    logic [7:0]      data_in;
    logic            rw_in;

    logic [7:0] dout   [NDUT];
    logic       busy_w [NDUT];
    logic       odv_w  [NDUT];
    logic       ovr_w  [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        main_mem #(
            .d_width (8),
            .a_width (8),
            .latency (g + 1)
        ) u_dut (
            .clk      (clk),
            .clr      (clr[g]),
            .addr_in  (addr_in),
            .data_in  (data_in),
            .rw_in    (rw_in),
            .ce_in    (ce[g]),
            .data_out (dout[g]),
            .busy     (busy_w[g]),
            .odv      (odv_w[g]),
            .ovr      (ovr_w[g])
        );
    end

    // Reference model: memory contents per instance, last read value, sticky flag
    logic [7:0] ref_mem   [NDUT][256];
    bit         ref_valid [NDUT][256];
    logic [7:0] exp_dout  [NDUT];
    logic       exp_ovr   [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    // One request on instance d (latency d+1). Entered and left at a falling
    // edge. Optionally disturbs the bus after sample poke_j (poke_ce=1 means
    // a strobe while busy). Expected timing: with acceptance at edge k, busy
    // is high after edges k..k+lat, odv only after edge k+lat.
    task automatic do_req(input int d, input logic rw, input logic [7:0] a,
                          input logic [7:0] wd, input int poke_j,
                          input logic poke_ce, input logic p_rw,
                          input logic [7:0] p_a, input logic [7:0] p_d,
                          input string tag);
        int   lat;
        int   waitc;
        logic exp_busy;
        logic exp_odv;
        lat   = d + 1;
        waitc = 0;
        while (busy_w[d] !== 1'b0 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (busy_w[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_wait: busy=%b required 0", tag, busy_w[d]);
        end
        addr_in = a;
        data_in = wd;
        rw_in   = rw;
        ce[d]   = 1'b1;
        for (int j = 0; j <= lat + 1; j++) begin
            @(negedge clk);
            exp_busy = (j <= lat);
            exp_odv  = (j == lat);
            if (j == lat) begin
                if (rw == RW_WRITE) begin
                    ref_mem[d][a]   = wd;
                    ref_valid[d][a] = 1'b1;
                end else begin
                    exp_dout[d] = ref_mem[d][a];
                end
            end
            if (poke_ce && j == poke_j + 1) exp_ovr[d] = 1'b1;
            n_checks++;
            if (busy_w[d] !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy j=%0d: got %b required %b", tag, j, busy_w[d], exp_busy);
            end
            n_checks++;
            if (odv_w[d] !== exp_odv) begin
                n_fail++;
                $display("FAIL %s odv j=%0d: got %b required %b", tag, j, odv_w[d], exp_odv);
            end
            n_checks++;
            if (dout[d] !== exp_dout[d]) begin
                n_fail++;
                $display("FAIL %s data_out j=%0d: got %h required %h", tag, j, dout[d], exp_dout[d]);
            end
            n_checks++;
            if (ovr_w[d] !== exp_ovr[d]) begin
                n_fail++;
                $display("FAIL %s ovr j=%0d: got %b required %b", tag, j, ovr_w[d], exp_ovr[d]);
            end
            // Scramble the bus; latched requests must not notice
            ce[d]   = 1'b0;
            addr_in = 8'($urandom);
            data_in = 8'($urandom);
            rw_in   = 1'($urandom);
            if (j == poke_j) begin
                ce[d]   = poke_ce;
                rw_in   = p_rw;
                addr_in = p_a;
                data_in = p_d;
            end
        end
        ce[d] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (busy_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset busy[%0d]: got %b required 0", d, busy_w[d]); end
            n_checks++;
            if (odv_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset odv[%0d]: got %b required 0", d, odv_w[d]); end
            n_checks++;
            if (ovr_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset ovr[%0d]: got %b required 0", d, ovr_w[d]); end
            n_checks++;
            if (dout[d] !== 8'h00) begin n_fail++; $display("FAIL reset data_out[%0d]: got %h required 00", d, dout[d]); end
        end
        clr = '1;
    endtask

    // Latency 3: reset lands in WAIT, once during a read and once during a write
    task automatic test_reset_mid_request();
        localparam int D = 2;
        do_req(D, RW_WRITE, 8'h40, 8'h6E, -1, 1'b0, 1'b0, 8'h00, 8'h00, "rst_pre40");
        do_req(D, RW_WRITE, 8'h41, 8'h12, -1, 1'b0, 1'b0, 8'h00, 8'h00, "rst_pre41");
        do_req(D, RW_READ,  8'h41, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "rst_rd41");
        for (int r = 0; r < 2; r++) begin
            addr_in = (r == 0) ? 8'h40 : 8'h41;
            data_in = 8'hEE;
            rw_in   = (r == 0) ? RW_READ : RW_WRITE;
            ce[D]   = 1'b1;
            @(negedge clk);
            ce[D] = 1'b0;
            @(negedge clk);
            #2 clr[D] = 1'b0;
            #1;
            n_checks++;
            if (busy_w[D] !== 1'b0) begin n_fail++; $display("FAIL midreset busy r=%0d: got %b required 0", r, busy_w[D]); end
            n_checks++;
            if (odv_w[D] !== 1'b0) begin n_fail++; $display("FAIL midreset odv r=%0d: got %b required 0", r, odv_w[D]); end
            n_checks++;
            if (dout[D] !== 8'h00) begin n_fail++; $display("FAIL midreset data_out r=%0d: got %h required 00", r, dout[D]); end
            exp_dout[D] = 8'h00;
            exp_ovr[D]  = 1'b0;
            @(negedge clk);
            clr[D] = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                n_checks++;
                if (odv_w[D] !== 1'b0 || busy_w[D] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL postreset quiet r=%0d c=%0d: odv=%b busy=%b required 0 0", r, c, odv_w[D], busy_w[D]);
                end
            end
        end
        // Discarded write leaves the old value; untouched location preserved
        do_req(D, RW_READ, 8'h41, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "rst_after41");
        do_req(D, RW_READ, 8'h40, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "rst_after40");
    endtask

    task automatic test_write_read();
        do_req(1, RW_WRITE, 8'h3C, 8'hA5, -1, 1'b0, 1'b0, 8'h00, 8'h00, "wr_3c");
        do_req(1, RW_READ,  8'h3C, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "rd_3c");
    endtask

    task automatic test_latency1();
        do_req(0, RW_WRITE, 8'h00, 8'h11, -1, 1'b0, 1'b0, 8'h00, 8'h00, "l1_wr");
        do_req(0, RW_READ,  8'h00, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "l1_rd");
    endtask

    // Latency 4: a write strobe two cycles into a read is dropped and flagged
    task automatic test_busy_overlap();
        do_req(3, RW_WRITE, 8'h10, 8'h33, -1, 1'b0, 1'b0, 8'h00, 8'h00, "ovr_pre");
        do_req(3, RW_READ,  8'h10, 8'h00, 1, 1'b1, RW_WRITE, 8'h10, 8'hFF, "ovr_rd");
        do_req(3, RW_READ,  8'h10, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "ovr_rd2");
    endtask

    task automatic test_input_change();
        do_req(1, RW_WRITE, 8'h20, 8'h5A, -1, 1'b0, 1'b0, 8'h00, 8'h00, "chg_pre20");
        do_req(1, RW_WRITE, 8'h21, 8'hC3, -1, 1'b0, 1'b0, 8'h00, 8'h00, "chg_pre21");
        do_req(1, RW_READ,  8'h20, 8'h00, 0, 1'b0, RW_WRITE, 8'h21, 8'h99, "chg_rd20");
        do_req(1, RW_READ,  8'h21, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "chg_rd21");
    endtask

    // Cache miss: write-back followed immediately by the fill read
    task automatic test_back_to_back();
        do_req(1, RW_WRITE, 8'h09, 8'h42, -1, 1'b0, 1'b0, 8'h00, 8'h00, "b2b_pre");
        do_req(1, RW_WRITE, 8'h05, 8'h77, -1, 1'b0, 1'b0, 8'h00, 8'h00, "b2b_wb");
        do_req(1, RW_READ,  8'h09, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "b2b_fill");
        do_req(1, RW_READ,  8'h05, 8'h00, -1, 1'b0, 1'b0, 8'h00, 8'h00, "b2b_chk05");
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic       rw;
        int         pj;
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 15; n++) begin
                a  = 8'(8'h80 + 8'($urandom_range(0, 7)));
                rw = (ref_valid[d][a] && ($urandom_range(0, 1) == 1)) ? RW_READ : RW_WRITE;
                pj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d + 1)) : -1;
                do_req(d, rw, a, 8'($urandom), pj, (pj >= 0), 1'($urandom),
                       8'($urandom), 8'($urandom), "rand");
            end
        end
    endtask

    initial begin
        clr     = '0;
        ce      = '0;
        addr_in = 8'h00;
        data_in = 8'h00;
        rw_in   = RW_READ;
        for (int d = 0; d < NDUT; d++) begin
            exp_dout[d] = 8'h00;
            exp_ovr[d]  = 1'b0;
            for (int i = 0; i < 256; i++) ref_valid[d][i] = 1'b0;
        end
        test_reset();
        test_reset_mid_request();
        test_write_read();
        test_latency1();
        test_busy_overlap();
        test_input_change();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule : tb_main_mem
